pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
Program-counter controller on the receiving end of the jump unit's pcoe/pcout interface. Holds the 16-bit PC, advances it on fetch, and loads jump targets when the jump unit asserts its load enable. Provides a hardware return-address stack for call/ret. Also owns the high-address-byte latch that supplies the upper byte of two-byte jump targets back to the jump unit.

Parameters:
DEPTH, 8, return-stack entries (power of 2, 2..16)
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
inc  input  1  advance PC by 1 this cycle (instruction/operand fetch)
ld  input  1  load request from jump unit (its pcoe)
ldval  input  16  load target from jump unit (its pcout)
call  input  1  push return address; qualified by ld
ret  input  1  pop return address into PC
hi_we  input  1  capture databus into high-byte latch
databus  input  8  system data bus
pc  output  16  current program counter
hibyte  output  8  high-byte latch, fed to jump unit
sp  output  $clog2(DEPTH)+1  stack occupancy, 0..DEPTH
full  output  1  sp == DEPTH
empty  output  1  sp == 0
ovf  output  1  sticky: push attempted while full
unf  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_PC, hibyte=0, sp=0, ovf=0, unf=0; stack contents are don't-care. Outputs take reset values immediately, not at the next edge.
- All state updates on posedge clk. The pc output is the register, so a load or increment is visible the cycle after the request.
- Priority per cycle: ret > ld > inc. A lower-priority request is ignored when a higher one is active.
- ret: if sp>0, pc <= stack[sp-1] and sp <= sp-1. If sp==0, pc is unchanged, unf <= 1, sp stays 0.
- ld without call: pc <= ldval. Any simultaneous inc is dropped.
- ld with call:
  - Pushed value is pc+1 (mod 2^16) when inc is also high, else pc.
  - If sp<DEPTH: stack[sp] <= pushed value, sp <= sp+1, pc <= ldval.
  - If sp==DEPTH: ovf <= 1, stack and sp unchanged, pc <= ldval (jump still taken).
- call without ld: ignored (conditional call not taken); no push.
- call with ret: ret wins; call ignored.
- inc alone: pc <= pc+1, wrapping 16'hFFFF -> 16'h0000 with no flag.
- hi_we: hibyte <= databus. hibyte is cleared to 0 on any cycle where ld is accepted and hi_we is low, so a stale high byte is never reused. If hi_we and ld occur in the same cycle, hi_we wins: hibyte <= databus.
- ovf and unf stay set until rst.
- full and empty are combinational from sp.
- Stack is a register array indexed by sp; no wrap-around: sp saturates at 0 and DEPTH.

Test Plan:
- Reset/inc: assert rst mid-run with pc=0x1234 -> pc=0x0000, sp=0 immediately; 3 inc cycles -> pc=0x0003; from pc=0xFFFF, inc -> pc=0x0000.
- Jump: pc=0x0010, ld=1, ldval=0x0200, inc=1 -> next pc=0x0200 (inc dropped); then hi_we with databus=0x12 -> hibyte=0x12; next ld -> hibyte=0x00.
- Call/ret: pc=0x0040, call+ld+inc, ldval=0x0300 -> pc=0x0300, sp=1; two inc; ret -> pc=0x0041, sp=0.
- Nesting/overflow (DEPTH=8): 8 calls from distinct PCs -> full=1; 9th call to 0x0500 -> pc=0x0500, ovf=1, sp=8; 8 rets pop the addresses in reverse order.
- Underflow: sp=0, pc=0x0077, ret -> pc=0x0077, unf=1; unf stays 1 after further traffic until rst.
- Priority: ret+ld+call+inc together with sp=1, stack top=0x0AAA -> pc=0x0AAA, sp=0, no push; call without ld -> no sp change.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program-counter controller: 16-bit PC with fetch increment, jump load,
// a hardware return-address stack for call/ret, and the jump high-byte latch.
module pc_ctrl #(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   input  logic                     ld,
   input  logic [15:0]              ldval,
   input  logic                     call,
   input  logic                     ret,
   input  logic                     hi_we,
   input  logic [7:0]               databus,
   output logic [15:0]              pc,
   output logic [7:0]               hibyte,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf,
   output logic                     unf
);

   localparam int             AW     = $clog2(DEPTH);
   localparam int             SPW    = AW + 1;
   localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
   localparam logic [SPW-1:0] SP_ONE = SPW'(1);

   logic [15:0]    pc_q,  pc_d;
   logic [7:0]     hib_q, hib_d;
   logic [SPW-1:0] sp_q,  sp_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;

   logic [15:0]    stack_q [DEPTH];
   logic           push_en;
   logic [15:0]    push_val;
   logic [AW-1:0]  push_idx;
   logic [AW-1:0]  top_idx;

   assign full     = (sp_q == SP_MAX);
   assign empty    = (sp_q == '0);
   assign push_idx = AW'(sp_q);
   assign top_idx  = AW'(sp_q - SP_ONE);

   // Priority is ret > ld > inc; hi_we is independent and overrides the
   // high-byte clear that an accepted jump would otherwise perform.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      pc_d     = pc_q;
      hib_d    = hib_q;
      sp_d     = sp_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      push_en  = 1'b0;
      push_val = inc ? (pc_q + 16'd1) : pc_q;

      if (ret) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SP_ONE;
         end
      end else if (ld) begin
         pc_d  = ldval;
         hib_d = 8'h00;
         if (call) begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push_en = 1'b1;
               sp_d    = sp_q + SP_ONE;
            end
         end
      end else if (inc) begin
         pc_d = pc_q + 16'd1;
      end

      if (hi_we) begin
         hib_d = databus;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         hib_q <= 8'h00;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         hib_q <= hib_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // NOTE: stack storage is not reset; entries above sp are never read.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= push_val;
      end
   end

   assign pc     = pc_q;
   assign hibyte = hib_q;
   assign sp     = sp_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;

endmodule
